// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: MIG command encodings, MIG bus
// widths and the read scheduler state type.
package mem_pkg;

  localparam int unsigned MIG_ADDR_WIDTH = 29;
  localparam int unsigned MIG_DATA_WIDTH = 256;

  typedef enum logic [2:0] {
    MIG_CMD_WRITE = 3'b000,
    MIG_CMD_READ  = 3'b001
  } mig_cmd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } mem_sched_state_t;

  // Width of a client ID; a single client still needs a 1-bit field.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/read_tag_fifo.sv
// First-word-fall-through FIFO of client IDs. The head entry is visible on
// head_o as soon as it is written (one cycle after push_i). Push while full
// and pop while empty are ignored.
module read_tag_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               head_o,
  output logic                           empty_o,
  output logic                           full_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-2 depth).
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/mem_read_scheduler.sv
// Read-side MIG command scheduler: round-robin arbitration between read
// clients, one READ command per grant, a tag FIFO of issuing client IDs and
// in-order steering of returned 2-beat bursts back to their client.
module mem_read_scheduler
  import mem_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned ADDR_WIDTH      = MIG_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = MIG_DATA_WIDTH
) (
  input  logic                                    clk_ram,
  input  logic                                    rst_n,
  input  logic                                    cmd_inhibit,
  input  logic [NUM_PORTS-1:0]                    rd_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]         rd_addr,
  output logic [NUM_PORTS-1:0]                    rd_ack,
  output logic [DATA_WIDTH-1:0]                   rd_data,
  output logic [NUM_PORTS-1:0]                    rd_data_valid,
  output logic                                    rd_data_end,
  output logic [ADDR_WIDTH-1:0]                   app_addr,
  output logic [2:0]                              app_cmd,
  output logic                                    app_en,
  input  logic                                    app_rdy,
  input  logic [DATA_WIDTH-1:0]                   app_rd_data,
  input  logic                                    app_rd_data_valid,
  input  logic                                    app_rd_data_end,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]    outstanding,
  output logic                                    err_orphan
);

  localparam int unsigned IDW = id_width(NUM_PORTS);
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_PORTS - 1);

  mem_sched_state_t state_q, state_d;

  logic [IDW-1:0]        rr_q, rr_d;
  logic [IDW-1:0]        win_q, win_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            cmd_q, cmd_d;

  logic                  grant_vld;
  logic [IDW-1:0]        grant_id;
  logic                  can_issue;
  logic                  start;
  logic                  accept;

  logic                  fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [IDW-1:0]        fifo_head;
  logic [CW-1:0]         fifo_count;
  logic [NUM_PORTS-1:0]  head_onehot;

  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [NUM_PORTS-1:0]  rd_valid_q;
  logic                  rd_end_q;
  logic                  err_q;

  // Round-robin winner: pointer port if requesting, else lowest requester.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    if (rd_req[rr_q]) begin
      grant_vld = 1'b1;
      grant_id  = rr_q;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (!grant_vld && rd_req[i]) begin
          grant_vld = 1'b1;
          grant_id  = IDW'(i);
        end
      end
    end
  end

  assign can_issue = !cmd_inhibit && (fifo_count < MAX_CNT);
  assign start     = (state_q == IDLE) && can_issue && grant_vld;
  assign accept    = (state_q == ISSUE) && app_rdy;

  // FSM state register.
  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: one command in flight on the port at a time.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)   state_d = ISSUE;
      ISSUE:   if (app_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: strobe held for the whole ISSUE state; ack is the handshake.
  always_comb begin
    app_en = (state_q == ISSUE);
    rd_ack = '0;
    if (accept) rd_ack[win_q] = 1'b1;
  end

  // Command/arbiter datapath next-state: capture on grant, advance rr on accept.
  always_comb begin
    addr_d = addr_q;
    cmd_d  = cmd_q;
    win_d  = win_q;
    rr_d   = rr_q;
    if (start) begin
      addr_d = rd_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
      cmd_d  = MIG_CMD_READ;
      win_d  = grant_id;
    end
    if (accept) begin
      rr_d = (win_q == LAST_ID) ? '0 : win_q + IDW'(1);
    end
  end

  // Command/arbiter datapath registers.
  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cmd_q  <= '0;
      win_q  <= '0;
      rr_q   <= '0;
    end else begin
      addr_q <= addr_d;
      cmd_q  <= cmd_d;
      win_q  <= win_d;
      rr_q   <= rr_d;
    end
  end

  assign app_addr = addr_q;
  assign app_cmd  = cmd_q;

  // The FIFO occupancy is the in-flight count, so no separate counter is kept.
  assign fifo_push = accept;
  assign fifo_pop  = app_rd_data_valid && app_rd_data_end && !fifo_empty;

  read_tag_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i       (clk_ram),
    .rst_ni      (rst_n),
    .push_i      (fifo_push),
    .push_data_i (win_q),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  assign outstanding = fifo_count;

  // Decode the tag at the FIFO head into the client qualifier.
  always_comb begin
    head_onehot = '0;
    head_onehot[fifo_head] = 1'b1;
  end

  // Return path: one-cycle registered steering plus sticky orphan flag.
  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      rd_end_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= '0;
      rd_end_q   <= 1'b0;
      if (app_rd_data_valid) begin
        rd_data_q <= app_rd_data;
        if (fifo_empty) begin
          err_q <= 1'b1;
        end else begin
          rd_valid_q <= head_onehot;
          rd_end_q   <= app_rd_data_end;
        end
      end
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;
  assign rd_data_end   = rd_end_q;
  assign err_orphan    = err_q;

  // A client must hold its request until the command is accepted.
  a_req_held: assert property (
    @(posedge clk_ram) disable iff (!rst_n) (state_q == ISSUE) |-> rd_req[win_q]
  );

  // Issue is gated on free credit, so the tag FIFO can never overflow.
  a_no_overflow: assert property (
    @(posedge clk_ram) disable iff (!rst_n) fifo_push |-> (!fifo_full || fifo_pop)
  );

endmodule

// File: tb/tb_mem_read_scheduler.sv
// Bench for mem_read_scheduler: a transaction-level model (pending command,
// queue of issued client IDs) checked against the DUT every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_mem_read_scheduler;

  localparam int NP   = 2;
  localparam int MAXO = 16;
  localparam int AW   = 29;
  localparam int DW   = 256;
  localparam int OW   = $clog2(MAXO + 1);

  logic              clk_ram = 1'b0;
  logic              rst_n;
  logic              cmd_inhibit;
  logic [NP-1:0]     rd_req;
  logic [NP*AW-1:0]  rd_addr;
  logic [NP-1:0]     rd_ack;
  logic [DW-1:0]     rd_data;
  logic [NP-1:0]     rd_data_valid;
  logic              rd_data_end;
  logic [AW-1:0]     app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DW-1:0]     app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;
  logic [OW-1:0]     outstanding;
  logic              err_orphan;

  mem_read_scheduler #(
    .NUM_PORTS       (NP),
    .MAX_OUTSTANDING (MAXO),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW)
  ) dut (
    .clk_ram           (clk_ram),
    .rst_n             (rst_n),
    .cmd_inhibit       (cmd_inhibit),
    .rd_req            (rd_req),
    .rd_addr           (rd_addr),
    .rd_ack            (rd_ack),
    .rd_data           (rd_data),
    .rd_data_valid     (rd_data_valid),
    .rd_data_end       (rd_data_end),
    .app_addr          (app_addr),
    .app_cmd           (app_cmd),
    .app_en            (app_en),
    .app_rdy           (app_rdy),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid),
    .app_rd_data_end   (app_rd_data_end),
    .outstanding       (outstanding),
    .err_orphan        (err_orphan)
  );

  always #5 clk_ram = ~clk_ram;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int            m_q[$];       // IDs of accepted commands awaiting data
  bit            m_pend;       // a command is being offered to MIG
  int            m_id;
  logic [AW-1:0] m_addr;
  int            m_rr;
  logic [NP-1:0] m_valid;
  logic          m_end;
  logic [DW-1:0] m_data;
  logic          m_err;
  int            m_pre;

  always @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pend  = 0;
      m_id    = 0;
      m_addr  = '0;
      m_rr    = 0;
      m_valid = '0;
      m_end   = 1'b0;
      m_data  = '0;
      m_err   = 1'b0;
    end else begin
      m_pre   = m_q.size();
      m_valid = '0;
      m_end   = 1'b0;
      if (app_rd_data_valid) begin
        if (m_pre == 0) m_err = 1'b1;
        else begin
          m_valid[m_q[0]] = 1'b1;
          m_data = app_rd_data;
          m_end  = app_rd_data_end;
          if (app_rd_data_end) void'(m_q.pop_front());
        end
      end
      if (m_pend) begin
        if (app_rdy) begin
          m_q.push_back(m_id);
          m_rr   = (m_id + 1) % NP;
          m_pend = 0;
        end
      end else if (!cmd_inhibit && m_pre < MAXO && rd_req != '0) begin
        if (rd_req[m_rr]) m_id = m_rr;
        else begin
          m_id = -1;
          for (int i = NP - 1; i >= 0; i--) if (rd_req[i]) m_id = i;
        end
        m_addr = rd_addr[m_id*AW +: AW];
        m_pend = 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_ram) begin
    if (rst_n) begin
      logic [NP-1:0] e_ack;
      e_ack = '0;
      if (m_pend && app_rdy) e_ack[m_id] = 1'b1;
      check("app_en", 64'(app_en), 64'(m_pend));
      if (m_pend) begin
        check("app_addr", 64'(app_addr), 64'(m_addr));
        check("app_cmd", 64'(app_cmd), 64'h1);
      end
      check("rd_ack", 64'(rd_ack), 64'(e_ack));
      check("rd_data_valid", 64'(rd_data_valid), 64'(m_valid));
      check("rd_data_end", 64'(rd_data_end), 64'(m_end));
      if (m_valid != '0) begin
        checks++;
        if (rd_data !== m_data) begin
          failures++;
          $display("FAIL rd_data actual=%0h required=%0h", rd_data[63:0], m_data[63:0]);
        end
      end
      check("outstanding", 64'(outstanding), 64'(m_q.size()));
      check("err_orphan", 64'(err_orphan), 64'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [AW-1:0] cur_addr[NP];
  int            remaining[NP];
  int            grants[$];
  logic          s_app_en, s_end, s_err;
  logic [AW-1:0] s_addr;
  logic [2:0]    s_cmd;
  logic [NP-1:0] s_ack, s_valid;
  logic [OW-1:0] s_out;

  task automatic drive_addr();
    for (int i = 0; i < NP; i++) rd_addr[i*AW +: AW] = cur_addr[i];
  endtask

  // One clock: snapshot outputs at negedge, then act as the clients after the edge.
  task automatic tick();
    @(negedge clk_ram);
    s_app_en = app_en;  s_addr = app_addr;   s_cmd = app_cmd; s_ack = rd_ack;
    s_valid  = rd_data_valid; s_end = rd_data_end; s_out = outstanding; s_err = err_orphan;
    for (int i = 0; i < NP; i++) if (s_ack[i]) grants.push_back(i);
    @(posedge clk_ram);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (s_ack[i]) begin
        remaining[i]--;
        cur_addr[i] = cur_addr[i] + AW'(32'h40);
        if (remaining[i] <= 0) rd_req[i] = 1'b0;
      end
    end
    drive_addr();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((rd_req != '0 || m_pend) && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 64'(rd_req != '0 || m_pend), 64'h0);
  endtask

  task automatic beat(input logic [31:0] pat, input logic last);
    app_rd_data_valid = 1'b1;
    app_rd_data       = {8{pat}};
    app_rd_data_end   = last;
    tick();
  endtask

  task automatic rd_idle();
    app_rd_data_valid = 1'b0;
    app_rd_data_end   = 1'b0;
  endtask

  task automatic burst(input logic [31:0] pat);
    beat(pat, 1'b0);
    beat(pat, 1'b1);
    rd_idle();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [1:0] exp_route[4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_inhibit = 1'b0; rd_req = '0; app_rdy = 1'b1;
    app_rd_data = '0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    cur_addr[0] = AW'(32'h100); cur_addr[1] = AW'(32'h2000);
    remaining[0] = 0; remaining[1] = 0;
    drive_addr();
    tick();
    check("rst_app_en", 64'(s_app_en), 64'h0);
    check("rst_app_addr", 64'(s_addr), 64'h0);
    check("rst_app_cmd", 64'(s_cmd), 64'h0);
    check("rst_valid", 64'(s_valid), 64'h0);
    check("rst_outstanding", 64'(s_out), 64'h0);
    rst_n = 1'b1;
    tick();

    // Single read: app_en one cycle after request, two beats to port 0.
    rd_req[0] = 1'b1; remaining[0] = 1;
    tick();
    check("single_en_n", 64'(s_app_en), 64'h0);
    tick();
    check("single_en_n1", 64'(s_app_en), 64'h1);
    check("single_addr", 64'(s_addr), 64'h100);
    check("single_cmd", 64'(s_cmd), 64'h1);
    check("single_ack", 64'(s_ack), 64'h1);
    tick();
    check("single_out1", 64'(s_out), 64'h1);
    for (int i = 0; i < 9; i++) tick();
    beat(32'hA5A5_0001, 1'b0);
    beat(32'hA5A5_0001, 1'b1);
    check("single_v1", 64'(s_valid), 64'h1);
    check("single_e1", 64'(s_end), 64'h0);
    rd_idle();
    tick();
    check("single_v2", 64'(s_valid), 64'h1);
    check("single_e2", 64'(s_end), 64'h1);
    check("single_out0", 64'(s_out), 64'h0);

    // Contention: both ports, two grants each, from a fresh rr pointer.
    apply_reset();
    grants.delete();
    rd_req = 2'b11; remaining[0] = 2; remaining[1] = 2;
    run_until_idle(30);
    check("cont_ngrants", 64'(grants.size()), 64'h4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      check("cont_grant", 64'(grants[k]), 64'(k % 2));
    tick();
    check("cont_out4", 64'(s_out), 64'h4);
    for (int k = 0; k < 4; k++) begin
      beat(32'hC0DE_0000 + 32'(k), 1'b0);
      beat(32'hC0DE_0000 + 32'(k), 1'b1);
      check("cont_route", 64'(s_valid), 64'(exp_route[k]));
    end
    rd_idle();
    tick();
    tick();
    check("cont_out0", 64'(s_out), 64'h0);

    // Back-pressure: MIG not ready for 5 cycles, then inhibit pulse.
    grants.delete();
    app_rdy = 1'b0; cur_addr[0] = AW'(32'h300); drive_addr();
    rd_req[0] = 1'b1; remaining[0] = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_en", 64'(s_app_en), 64'h1);
      check("bp_addr", 64'(s_addr), 64'h300);
    end
    cmd_inhibit = 1'b1;
    tick();
    tick();
    check("bp_inh_en", 64'(s_app_en), 64'h1);
    check("bp_inh_addr", 64'(s_addr), 64'h300);
    cmd_inhibit = 1'b0; app_rdy = 1'b1;
    tick();
    check("bp_ack", 64'(s_ack), 64'h1);
    tick();
    check("bp_en_drop", 64'(s_app_en), 64'h0);
    check("bp_one_ack", 64'(grants.size()), 64'h1);
    burst(32'hBEEF_0000);
    tick();
    tick();

    // Credit limit: 16 accepts then stall; one return releases the 17th.
    grants.delete();
    rd_req[0] = 1'b1; remaining[0] = 18;
    for (int i = 0; i < 36; i++) tick();
    check("credit_acc16", 64'(grants.size()), 64'd16);
    check("credit_out16", 64'(s_out), 64'd16);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("credit_stall", 64'(s_app_en), 64'h0);
    end
    beat(32'h1111_0000, 1'b0);
    beat(32'h1111_0000, 1'b1);
    beat(32'h1111_0001, 1'b0);
    check("credit_pop_en", 64'(s_app_en), 64'h0);
    check("credit_out15", 64'(s_out), 64'd15);
    beat(32'h1111_0001, 1'b1);
    check("credit_17_en", 64'(s_app_en), 64'h1);
    check("credit_17_ack", 64'(s_ack), 64'h1);
    rd_idle();
    tick();
    check("credit_same_edge", 64'(s_out), 64'd15);
    tick(); tick(); tick();
    check("credit_refill", 64'(s_out), 64'd16);
    check("credit_acc18", 64'(grants.size()), 64'd18);
    for (int k = 0; k < 16; k++) burst(32'h2222_0000 + 32'(k));
    tick();
    tick();
    check("credit_drain", 64'(s_out), 64'h0);

    // Inhibit holds off issue; release gives app_en on the following cycle.
    cmd_inhibit = 1'b1;
    rd_req[1] = 1'b1; remaining[1] = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("inh_en", 64'(s_app_en), 64'h0);
    end
    cmd_inhibit = 1'b0;
    tick();
    check("inh_rel_n", 64'(s_app_en), 64'h0);
    tick();
    check("inh_rel_en", 64'(s_app_en), 64'h1);
    check("inh_rel_ack", 64'(s_ack), 64'h2);
    burst(32'h3333_0000);
    tick();
    tick();

    // Reset with reads in flight: later data is orphaned.
    rd_req[0] = 1'b1; remaining[0] = 2;
    run_until_idle(20);
    tick();
    check("orph_out2", 64'(s_out), 64'h2);
    rst_n = 1'b0;
    tick();
    check("orph_rst_out", 64'(s_out), 64'h0);
    check("orph_rst_err", 64'(s_err), 64'h0);
    rst_n = 1'b1;
    tick();
    burst(32'h4444_0000);
    tick();
    check("orph_valid", 64'(s_valid), 64'h0);
    check("orph_err", 64'(s_err), 64'h1);
    tick();
    check("orph_sticky", 64'(s_err), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
